z80_wb_arbiter: RTL and testbench
=================================

Z80_WB_ARBITER -- requirements
Module: z80_wb_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, bus-stall cycle limit before error termination (legal range 1..255).
REQ-002 wb_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 wb_rst_i  input  1  reset; synchronous, active-high.
REQ-004 m0_cyc_i / m1_cyc_i  input  1  bus request, master 0 (Z80 core) / master 1 (DMA/debug).
REQ-005 m0_stb_i / m1_stb_i  input  1  strobe.
REQ-006 m0_we_i / m1_we_i  input  1  write enable.
REQ-007 m0_adr_i / m1_adr_i  input  16  address.
REQ-008 m0_dat_i / m1_dat_i  input  8  write data.
REQ-009 m0_tga_i / m1_tga_i  input  2  address tag (memory/io/interrupt cycle type).
REQ-010 m0_ack_o / m1_ack_o  output  1  transfer acknowledge to master.
REQ-011 m0_err_o / m1_err_o  output  1  timeout error termination to master.
REQ-012 m_dat_o  output  8  read data, broadcast to both masters.
REQ-013 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  shared slave bus controls.
REQ-014 wb_adr_o  output  16; wb_dat_o  output  8; wb_tga_o  output  2  shared slave bus address/data/tag.
REQ-015 wb_ack_i  input  1; wb_dat_i  input  8  slave acknowledge and read data.
REQ-016 arb_gnt_o  output  2  one-hot grant status {m1,m0}; 2'b00 when idle.

Function
REQ-017 FSM states IDLE, GNT0, GNT1; state registered, grant decoded from state.
REQ-018 IDLE: if exactly one mX_cyc_i high, go to GNTX next edge.
REQ-019 IDLE with both cyc high: grant master not granted last (rr pointer); pointer updates on every grant entry.
REQ-020 GNTX: stay while mX_cyc_i high; on mX_cyc_i low go to IDLE (one idle cycle between tenures, no direct GNT0<->GNT1).
REQ-021 Latency: cyc rising in IDLE at edge N -> wb_cyc_o high after edge N+1; no combinational cyc_i->wb_cyc_o path in IDLE.
REQ-022 In GNTX, wb_cyc_o/stb_o/we_o/adr_o/dat_o/tga_o combinationally equal master X inputs.
REQ-023 In IDLE, all wb_*_o driven 0.
REQ-024 mX_ack_o = wb_ack_i AND state==GNTX AND mX_stb_i; non-granted master ack always 0.
REQ-025 m_dat_o = wb_dat_i at all times.
REQ-026 wb_ack_i in IDLE ignored, no state change.
REQ-027 Watchdog: 8-bit counter increments each cycle wb_stb_o=1 and wb_ack_i=0; clears on wb_ack_i=1, wb_stb_o=0, or state change.
REQ-028 When counter == TIMEOUT-1 and wb_ack_i=0 while stb high: granted mX_err_o pulses high one cycle, counter clears; grant retained.
REQ-029 err and ack never both high in same cycle; ack wins (counter cleared).
REQ-030 Granted master drops cyc same cycle other raises cyc: IDLE next edge, other master granted the edge after.
REQ-031 Granted master holding cyc indefinitely is not preempted.

Reset
REQ-032 wb_rst_i high at any edge, including mid-transfer: state IDLE, rr pointer favours m0, watchdog 0.
REQ-033 While/after reset: all wb_*_o 0, mX_ack_o 0, mX_err_o 0, arb_gnt_o 2'b00.

Verification
REQ-034 m0 cyc/stb, we=1, adr=16'h1234, dat=8'hA5 -> wb_* mirror m0 one cycle after request, arb_gnt_o=2'b01, wb_ack_i -> m0_ack_o=1, m1_ack_o=0.
REQ-035 Both cyc raised same cycle after reset -> m0 granted; m0 releases -> one IDLE cycle -> m1 granted (arb_gnt_o 01,00,10).
REQ-036 Both held requesting across alternating releases for 4 tenures -> grants alternate m0,m1,m0,m1.
REQ-037 TIMEOUT=4, m1 granted, stb high, no wb_ack_i -> m1_err_o pulses in 4th stalled cycle, counter restarts, m1_ack_o stays 0.
REQ-038 wb_rst_i asserted during GNT1 transfer -> next edge arb_gnt_o=00, wb_cyc_o=0; with both requesting after release, m0 granted first.
REQ-039 wb_ack_i pulsed while IDLE -> no ack to either master, state unchanged.

Source files
------------

// File: rtl/z80_wb_arbiter.sv
// -----------------------------------------------------------------------------
// z80_wb_arbiter
//
// Two-master Wishbone arbiter placed in front of a single shared slave bus.
// Master 0 is the Z80 core, master 1 is a DMA / debug port. A three-state
// FSM (IDLE, GNT0, GNT1) owns the bus. Grants are never taken from a master
// while it holds cyc, and every tenure is followed by at least one IDLE cycle.
// Simultaneous requests in IDLE are resolved round-robin.
//
// A watchdog counts stalled strobe cycles. When the slave fails to acknowledge
// within TIMEOUT cycles, the granted master receives a single-cycle error
// termination. The grant itself is kept.
//
// Parameters
//   TIMEOUT      stalled-cycle limit before an error pulse (1..255)
//
// Ports
//   wb_clk_i     clock, all state changes on its rising edge
//   wb_rst_i     synchronous active-high reset
//   m0_*_i       master 0 request: cyc, stb, we, adr[15:0], dat[7:0], tga[1:0]
//   m1_*_i       master 1 request, same set of signals as master 0
//   m0/m1_ack_o  transfer acknowledge to each master
//   m0/m1_err_o  timeout error termination to each master
//   m_dat_o      read data, broadcast to both masters
//   wb_*_o       shared slave bus: cyc, stb, we, adr, dat, tga
//   wb_ack_i     slave acknowledge
//   wb_dat_i     slave read data
//   arb_gnt_o    one-hot grant status {m1, m0}; 2'b00 when idle
// -----------------------------------------------------------------------------
module z80_wb_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [15:0] m0_adr_i,
    input  logic [7:0]  m0_dat_i,
    input  logic [1:0]  m0_tga_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [15:0] m1_adr_i,
    input  logic [7:0]  m1_dat_i,
    input  logic [1:0]  m1_tga_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [7:0]  m_dat_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [7:0]  wb_dat_o,
    output logic [1:0]  wb_tga_o,
    input  logic        wb_ack_i,
    input  logic [7:0]  wb_dat_i,

    output logic [1:0]  arb_gnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // The watchdog fires when the count reaches TIMEOUT-1 on a stalled cycle.
    // That cycle is the TIMEOUT-th stalled cycle of the tenure.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last_m1;     // 1: master 1 held the most recent grant
    logic [7:0] wd_cnt;

    logic       gnt0;
    logic       gnt1;
    logic       leaving;
    logic       wd_expire;

    // Grants are masked while reset is high. The bus therefore reads as idle
    // during reset as well as after it, not only from the next edge onward.
    assign gnt0 = (state == GNT0) && !wb_rst_i;
    assign gnt1 = (state == GNT1) && !wb_rst_i;

    assign arb_gnt_o = {gnt1, gnt0};

    // The granted master has released its cycle. The state changes on this edge.
    assign leaving = (state == GNT0 && !m0_cyc_i) || (state == GNT1 && !m1_cyc_i);

    // A slave ack in the same cycle wins over the timeout. Ack and error are
    // therefore never high together.
    assign wd_expire = wb_stb_o && !wb_ack_i && (wd_cnt == WD_LIMIT);

    // -------------------------------------------------------------------------
    // Arbitration FSM, round-robin pointer and watchdog counter
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments only. Every read in
    // this block then sees the pre-edge value, whatever order the statements
    // are written in.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            last_m1 <= 1'b1;      // makes m0 the winner of the first tie
            wd_cnt  <= 8'd0;
        end else begin
            // Watchdog: count stalled strobe cycles within a single tenure.
            if (leaving || !wb_stb_o || wb_ack_i || wd_expire) begin
                wd_cnt <= 8'd0;
            end else begin
                wd_cnt <= wd_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    // Only registered state reaches the bus. A request raised
                    // here is seen on wb_cyc_o one edge later.
                    if (m0_cyc_i && m1_cyc_i) begin
                        if (last_m1) begin
                            state   <= GNT0;
                            last_m1 <= 1'b0;
                        end else begin
                            state   <= GNT1;
                            last_m1 <= 1'b1;
                        end
                    end else if (m0_cyc_i) begin
                        state   <= GNT0;
                        last_m1 <= 1'b0;
                    end else if (m1_cyc_i) begin
                        state   <= GNT1;
                        last_m1 <= 1'b1;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) state <= IDLE;
                end
                GNT1: begin
                    if (!m1_cyc_i) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus multiplexer: the granted master drives the slave bus directly
    // -------------------------------------------------------------------------
    // NOTE: every output is given a default before the if-chain, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = 16'h0000;
        wb_dat_o = 8'h00;
        wb_tga_o = 2'b00;
        if (gnt0) begin
            wb_cyc_o = m0_cyc_i;
            wb_stb_o = m0_stb_i;
            wb_we_o  = m0_we_i;
            wb_adr_o = m0_adr_i;
            wb_dat_o = m0_dat_i;
            wb_tga_o = m0_tga_i;
        end else if (gnt1) begin
            wb_cyc_o = m1_cyc_i;
            wb_stb_o = m1_stb_i;
            wb_we_o  = m1_we_i;
            wb_adr_o = m1_adr_i;
            wb_dat_o = m1_dat_i;
            wb_tga_o = m1_tga_i;
        end
    end

    // A slave ack in IDLE reaches neither master.
    assign m0_ack_o = wb_ack_i && gnt0 && m0_stb_i;
    assign m1_ack_o = wb_ack_i && gnt1 && m1_stb_i;

    assign m0_err_o = gnt0 && wd_expire;
    assign m1_err_o = gnt1 && wd_expire;

    assign m_dat_o = wb_dat_i;

endmodule

// File: tb/tb_z80_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_z80_wb_arbiter
//
// Directed testbench for z80_wb_arbiter, built with TIMEOUT = 4. Inputs change
// 1 ns after a rising edge. Outputs are compared after a further 1 ns settle,
// well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_z80_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        m0_cyc, m0_stb, m0_we;
    logic [15:0] m0_adr;
    logic [7:0]  m0_dat;
    logic [1:0]  m0_tga;
    logic        m0_ack, m0_err;

    logic        m1_cyc, m1_stb, m1_we;
    logic [15:0] m1_adr;
    logic [7:0]  m1_dat;
    logic [1:0]  m1_tga;
    logic        m1_ack, m1_err;

    logic [7:0]  m_dat;
    logic        wb_cyc, wb_stb, wb_we;
    logic [15:0] wb_adr;
    logic [7:0]  wb_dat;
    logic [1:0]  wb_tga;
    logic        wb_ack;
    logic [7:0]  wb_dat_in;
    logic [1:0]  gnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    z80_wb_arbiter #(.TIMEOUT(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),
        .m0_adr_i (m0_adr),
        .m0_dat_i (m0_dat),
        .m0_tga_i (m0_tga),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),
        .m1_adr_i (m1_adr),
        .m1_dat_i (m1_dat),
        .m1_tga_i (m1_tga),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .m_dat_o  (m_dat),
        .wb_cyc_o (wb_cyc),
        .wb_stb_o (wb_stb),
        .wb_we_o  (wb_we),
        .wb_adr_o (wb_adr),
        .wb_dat_o (wb_dat),
        .wb_tga_o (wb_tga),
        .wb_ack_i (wb_ack),
        .wb_dat_i (wb_dat_in),
        .arb_gnt_o(gnt)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_tga = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_tga = '0;
        wb_ack = 0; wb_dat_in = '0;

        // ---- reset state ----
        tick();
        tick();
        settle();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_wb_cyc", 32'(wb_cyc), 32'h0);
        check("rst_m0_ack", 32'(m0_ack), 32'h0);
        rst = 1'b0;

        // ---- single m0 write: one-cycle latency, bus mirrors m0 ----
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 16'h1234; m0_dat = 8'hA5; m0_tga = 2'b10;
        settle();
        check("lat_no_comb_cyc", 32'(wb_cyc), 32'h0);
        check("lat_gnt_idle", 32'(gnt), 32'h0);
        tick();
        settle();
        check("m0_gnt", 32'(gnt), 32'h1);
        check("m0_wb_cyc", 32'(wb_cyc), 32'h1);
        check("m0_wb_stb", 32'(wb_stb), 32'h1);
        check("m0_wb_we", 32'(wb_we), 32'h1);
        check("m0_wb_adr", 32'(wb_adr), 32'h1234);
        check("m0_wb_dat", 32'(wb_dat), 32'hA5);
        check("m0_wb_tga", 32'(wb_tga), 32'h2);
        check("m0_ack_before", 32'(m0_ack), 32'h0);
        wb_ack = 1; wb_dat_in = 8'h3C;
        settle();
        check("m0_ack", 32'(m0_ack), 32'h1);
        check("m1_ack_not_gnt", 32'(m1_ack), 32'h0);
        check("m_dat_bcast", 32'(m_dat), 32'h3C);
        check("m0_err_on_ack", 32'(m0_err), 32'h0);
        wb_ack = 0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0;
        tick();
        settle();
        check("m0_release_gnt", 32'(gnt), 32'h0);
        check("m0_release_cyc", 32'(wb_cyc), 32'h0);

        // ---- slave ack while idle is ignored ----
        wb_ack = 1;
        settle();
        check("idle_ack_m0", 32'(m0_ack), 32'h0);
        check("idle_ack_m1", 32'(m1_ack), 32'h0);
        tick();
        settle();
        check("idle_ack_gnt", 32'(gnt), 32'h0);
        wb_ack = 0;

        // ---- simultaneous request after reset: m0 first, then m1 ----
        rst = 1;
        tick();
        rst = 0;
        m0_cyc = 1; m0_adr = 16'h1111;
        m1_cyc = 1; m1_adr = 16'hABCD;
        tick();
        settle();
        check("tie_gnt_m0", 32'(gnt), 32'h1);
        check("tie_adr_m0", 32'(wb_adr), 32'h1111);
        m0_cyc = 0;
        tick();
        settle();
        check("tie_idle_gap", 32'(gnt), 32'h0);
        tick();
        settle();
        check("tie_gnt_m1", 32'(gnt), 32'h2);
        check("tie_adr_m1", 32'(wb_adr), 32'hABCD);

        // ---- four tenures with both masters requesting: m0, m1, m0, m1 ----
        for (int k = 0; k < 4; k++) begin
            if (gnt == 2'b10) begin
                m1_cyc = 0; m0_cyc = 1;
            end else begin
                m0_cyc = 0; m1_cyc = 1;
            end
            tick();
            settle();
            check("rr_idle_gap", 32'(gnt), 32'h0);
            m0_cyc = 1; m1_cyc = 1;
            tick();
            settle();
            check("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            settle();
            check("rr_no_preempt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
        end

        // ---- watchdog on m1 with TIMEOUT = 4 ----
        m0_cyc = 0; m1_cyc = 0;
        tick();
        m1_cyc = 1; m1_stb = 1;
        tick();
        settle();
        check("wd_gnt_m1", 32'(gnt), 32'h2);
        check("wd_stall1_err", 32'(m1_err), 32'h0);
        tick();
        settle();
        check("wd_stall2_err", 32'(m1_err), 32'h0);
        tick();
        settle();
        check("wd_stall3_err", 32'(m1_err), 32'h0);
        tick();
        settle();
        check("wd_stall4_err", 32'(m1_err), 32'h1);
        check("wd_stall4_ack", 32'(m1_ack), 32'h0);
        check("wd_stall4_m0_err", 32'(m0_err), 32'h0);
        tick();
        settle();
        check("wd_restart_err", 32'(m1_err), 32'h0);
        check("wd_grant_kept", 32'(gnt), 32'h2);
        tick();
        tick();
        settle();
        check("wd_second_stall3", 32'(m1_err), 32'h0);
        tick();
        wb_ack = 1;
        settle();
        check("wd_ack_wins_ack", 32'(m1_ack), 32'h1);
        check("wd_ack_wins_err", 32'(m1_err), 32'h0);
        wb_ack = 0;
        tick();
        settle();
        check("wd_after_ack_err", 32'(m1_err), 32'h0);

        // ---- reset during an m1 transfer ----
        m0_cyc = 1;
        rst = 1;
        settle();
        check("mid_rst_gnt_during", 32'(gnt), 32'h0);
        check("mid_rst_err_during", 32'(m1_err), 32'h0);
        tick();
        settle();
        check("mid_rst_gnt", 32'(gnt), 32'h0);
        check("mid_rst_wb_cyc", 32'(wb_cyc), 32'h0);
        rst = 0;
        tick();
        settle();
        check("post_rst_m0_first", 32'(gnt), 32'h1);

        // ---- m0 releases as m1 raises in the same cycle ----
        m1_cyc = 0; m1_stb = 0;
        tick();
        settle();
        check("handoff_hold", 32'(gnt), 32'h1);
        m0_cyc = 0; m1_cyc = 1;
        tick();
        settle();
        check("handoff_idle", 32'(gnt), 32'h0);
        tick();
        settle();
        check("handoff_m1", 32'(gnt), 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
